// File: rtl/systolic_link_pkg.sv
// Shared tile configuration, link handshake port macros, and the systolic link vector type.
`ifndef TAU_HS_MACROS
`define TAU_HS_MACROS
`define TAU_HS_SINK(RDY, ACK, DATA, T) input logic RDY, output logic ACK, input T DATA
`define TAU_HS_SRC(RDY, ACK, DATA, T) output logic RDY, input logic ACK, output T DATA
`endif

package TauCfg;
    localparam int DBW   = 16;
    localparam int VSIZE = 4;
endpackage

package systolic_link_pkg;
    import TauCfg::*;
    typedef logic [VSIZE-1:0][DBW-1:0] vec_t;
endpackage

// File: rtl/systolic_link_fifo.sv
// One direction of the link: small FIFO with registered head, occupancy and delivered-beat counter.
module SystolicLinkFifo
    import systolic_link_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int CNT_BW = 16,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_rdy,
    output logic              o_in_ack,
    input  vec_t              i_in_data,
    output logic              o_out_rdy,
    input  logic              i_out_ack,
    output vec_t              o_out_data,
    output logic [CNT_BW-1:0] o_cnt,
    output logic [OCC_W-1:0]  o_occ
);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] ONE  = OCC_W'(1);

    vec_t              r_mem [DEPTH];
    vec_t              r_head;
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic [CNT_BW-1:0] r_cnt;
    logic [PTR_W-1:0]  w_rd_nxt;
    logic              w_push, w_pop;

    // Full blocks the push even when a pop lands on the same edge.
    assign w_push   = i_in_rdy && (r_occ != FULL) && !i_rst;
    assign w_pop    = i_out_ack && (r_occ != '0);
    assign w_rd_nxt = r_rd_ptr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
                r_cnt    <= r_cnt + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Head register tracks the oldest entry so out_data leaves straight from a flop.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_in_data;
        if (w_pop && (r_occ > ONE))
            r_head <= r_mem[w_rd_nxt];
        else if (w_push && ((r_occ == '0) || (w_pop && (r_occ == ONE))))
            r_head <= i_in_data;
    end

    assign o_in_ack   = w_push;
    assign o_out_rdy  = (r_occ != '0);
    assign o_out_data = r_head;
    assign o_cnt      = r_cnt;
    assign o_occ      = r_occ;
endmodule

// File: rtl/systolic_link.sv
// Bidirectional systolic link between neighbouring tiles: two independent single-direction FIFOs.
module systolic_link
    import systolic_link_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int CNT_BW = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    `TAU_HS_SINK(r_in_rdy, r_in_ack, r_in_data, vec_t),
    `TAU_HS_SRC(r_out_rdy, r_out_ack, r_out_data, vec_t),
    `TAU_HS_SINK(l_in_rdy, l_in_ack, l_in_data, vec_t),
    `TAU_HS_SRC(l_out_rdy, l_out_ack, l_out_data, vec_t),
    output logic [CNT_BW-1:0]            r_cnt,
    output logic [CNT_BW-1:0]            l_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   r_occ,
    output logic [$clog2(DEPTH+1)-1:0]   l_occ
);
    SystolicLinkFifo #(.DEPTH(DEPTH), .CNT_BW(CNT_BW)) u_rgt (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_in_rdy(r_in_rdy), .o_in_ack(r_in_ack), .i_in_data(r_in_data),
        .o_out_rdy(r_out_rdy), .i_out_ack(r_out_ack), .o_out_data(r_out_data),
        .o_cnt(r_cnt), .o_occ(r_occ)
    );

    SystolicLinkFifo #(.DEPTH(DEPTH), .CNT_BW(CNT_BW)) u_lft (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_in_rdy(l_in_rdy), .o_in_ack(l_in_ack), .i_in_data(l_in_data),
        .o_out_rdy(l_out_rdy), .i_out_ack(l_out_ack), .o_out_data(l_out_data),
        .o_cnt(l_cnt), .o_occ(l_occ)
    );
endmodule

// File: doc/systolic_link.md
SYSTOLIC_LINK -- requirements
Module: systolic_link

Interface
REQ-001 SHALL take parameter DEPTH, default 2, meaning entries per direction; legal values 2 or 4.
REQ-002 SHALL take parameter CNT_BW, default 16, meaning width of the per-direction beat counters.
REQ-003 SHALL use one clock and a synchronous, active-high reset: i_clk  input  1  clock; i_rst  input  1  synchronous active-high reset.
REQ-004 r_in_rdy  input  1  rightward beat valid, from the left tile's switch dst1.
REQ-005 r_in_ack  output  1  rightward beat accepted.
REQ-006 r_in_data  input  DBW x VSIZE  rightward vector.
REQ-007 r_out_rdy  output  1  rightward beat available, to the right tile's switch src0.
REQ-008 r_out_ack  input  1  rightward beat consumed.
REQ-009 r_out_data  output  DBW x VSIZE  rightward vector.
REQ-010 l_in_rdy / l_in_ack / l_in_data  input / output / input  1 / 1 / DBW x VSIZE  leftward beat, from the right tile's dst0.
REQ-011 l_out_rdy / l_out_ack / l_out_data  output / input / output  1 / 1 / DBW x VSIZE  leftward beat, to the left tile's src1.
REQ-012 r_cnt, l_cnt  output  CNT_BW  count of beats delivered on each output.
REQ-013 r_occ, l_occ  output  clog2(DEPTH+1)  current occupancy of each direction.

Function
REQ-014 Directions SHALL be independent; no signal of one direction SHALL affect the other.
REQ-015 A transfer SHALL occur on a rising edge where rdy and ack are both high; the producer SHALL hold rdy and data until ack.
REQ-016 in_ack SHALL equal in_rdy AND (occ < DEPTH); it SHALL NOT depend combinationally on out_ack.
REQ-017 out_rdy SHALL equal (occ != 0); out_data SHALL be the oldest entry, driven from a register.
REQ-018 Latency: a beat accepted at edge t SHALL be visible on out_rdy/out_data in cycle t+1, with FIFO ordering.
REQ-019 A simultaneous push and pop SHALL leave occ unchanged, including at occ == DEPTH-1 and at occ == 1.
REQ-020 At full (occ == DEPTH), in_ack SHALL be 0 even if out_ack is high in the same cycle.
REQ-021 At empty, out_rdy SHALL be 0 and out_data SHALL hold its last value (don't-care for checking).
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 cnt SHALL increment by 1 on each output transfer and wrap from 2^CNT_BW-1 to 0.
REQ-024 Data SHALL pass unmodified across all VSIZE lanes.

Reset
REQ-025 While i_rst is high at a clock edge: occ=0, pointers=0, cnt=0, r_out_rdy=l_out_rdy=0, and in_ack=0 in that cycle.
REQ-026 Reset asserted mid-operation SHALL discard buffered beats, with no partial delivery afterwards.
REQ-027 Entry storage SHALL need no reset.

Structure
REQ-028 DBW and VSIZE SHALL come from TauCfg; this block SHALL NOT add new package constants.
REQ-029 One sub-module, SystolicLinkFifo (single direction: buffer, pointers, occupancy, counter), SHALL be instantiated twice.
REQ-030 Handshake port groups SHALL use the shared rdy/ack port macros.

Verification
REQ-031 Reset, then push rightward beats A, B with r_out_ack=0 -> r_occ=2, r_in_ack=0 on beat C; r_out_data=A.
REQ-032 Full with r_in_rdy=1 and r_out_ack=1 in the same cycle -> A delivered, C not accepted that cycle; C accepted next cycle, r_occ=2.
REQ-033 Continuous push/pop at occ=1 for 100 cycles -> 100 beats, in order, occ stays 1, r_cnt=100.
REQ-034 Drive 65537 beats with CNT_BW=16 -> r_cnt=1.
REQ-035 Rightward stalled and full while leftward streams 10 beats -> l_cnt=10, r_occ unchanged.
REQ-036 Assert i_rst with occ=2 -> next cycle out_rdy=0, occ=0, cnt=0; the next beat pushed is the first delivered.
